// File: rtl/sa2x2_if.sv
// sa2x2_if: operand load, run control, array feed and result handshake bundle for sa2x2_ctrl.
interface sa2x2_if #(parameter int DW = 8);
   logic          ld_valid;
   logic          ld_ready;
   logic [2:0]    ld_addr;
   logic [DW-1:0] ld_data;
   logic          start;
   logic          busy;
   logic          sa_clear;
   logic [DW-1:0] sa_din0;
   logic [DW-1:0] sa_din1;
   logic [DW-1:0] sa_win0;
   logic [DW-1:0] sa_win1;
   logic [DW-1:0] sa_out;
   logic          res_valid;
   logic          res_ready;
   logic [DW-1:0] res_data;
   modport slave (
      input  ld_valid, ld_addr, ld_data, start, sa_out, res_ready,
      output ld_ready, busy, sa_clear, sa_din0, sa_din1, sa_win0, sa_win1, res_valid, res_data
   );
   modport master (
      output ld_valid, ld_addr, ld_data, start, sa_out, res_ready,
      input  ld_ready, busy, sa_clear, sa_din0, sa_din1, sa_win0, sa_win1, res_valid, res_data
   );
endinterface

// File: rtl/sa2x2_ctrl.sv
// sa2x2_ctrl: loads 2x2 data/weight operands, sequences clear/feed/drain of a 2x2 systolic array
// and holds the captured array result until the consumer accepts it.
module sa2x2_ctrl #(
   parameter int DW = 8,
   parameter int DRAIN_CYC = 3
) (
   input logic clk,
   input logic rst,
   sa2x2_if.slave bus
);
   typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;
   state_t state, state_n;
   logic [1:0] f, f_n;
   logic [3:0] dc, dc_n;
   logic [DW-1:0] d [4];
   logic [DW-1:0] w [4];
   logic [DW-1:0] din0, din1, win0, win1, res;
   logic [DW-1:0] din0_n, din1_n, win0_n, win1_n;
   logic s0, s1, s2, cap, wr;
   assign wr  = bus.ld_valid && state == IDLE;
   assign cap = state == DRAIN && dc == 4'(DRAIN_CYC - 1);
   // feeds are registered, so decode the step that the next cycle will present
   assign s0 = state == CLEAR;
   assign s1 = state == FEED && f == 2'd0;
   assign s2 = state == FEED && f == 2'd1;
   assign din0_n = s0 ? d[0] : s1 ? d[1] : '0;
   assign din1_n = s1 ? d[2] : s2 ? d[3] : '0;
   assign win0_n = s0 ? w[0] : s1 ? w[1] : '0;
   assign win1_n = s1 ? w[2] : s2 ? w[3] : '0;
   always_comb begin
      state_n = state;
      f_n = f;
      dc_n = dc;
      case (state)
         IDLE:  state_n = bus.start ? CLEAR : IDLE;
         CLEAR: begin
            state_n = FEED;
            f_n = '0;
         end
         FEED:  begin
            state_n = f == 2'd2 ? DRAIN : FEED;
            f_n = f + 2'd1;
            dc_n = '0;
         end
         DRAIN: begin
            state_n = cap ? DONE : DRAIN;
            dc_n = dc + 4'd1;
         end
         DONE:  state_n = bus.res_ready ? IDLE : DONE;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         f <= '0;
         dc <= '0;
         d <= '{default: '0};
         w <= '{default: '0};
         din0 <= '0;
         din1 <= '0;
         win0 <= '0;
         win1 <= '0;
         res <= '0;
      end else begin
         state <= state_n;
         f <= f_n;
         dc <= dc_n;
         din0 <= din0_n;
         din1 <= din1_n;
         win0 <= win0_n;
         win1 <= win1_n;
         if (cap) res <= bus.sa_out;
         if (wr && bus.ld_addr[2]) w[bus.ld_addr[1:0]] <= bus.ld_data;
         if (wr && !bus.ld_addr[2]) d[bus.ld_addr[1:0]] <= bus.ld_data;
      end
   end
   assign bus.ld_ready  = state == IDLE;
   assign bus.busy      = state != IDLE;
   assign bus.sa_clear  = state == CLEAR;
   assign bus.res_valid = state == DONE;
   assign bus.sa_din0   = din0;
   assign bus.sa_din1   = din1;
   assign bus.sa_win0   = win0;
   assign bus.sa_win1   = win1;
   assign bus.res_data  = res;
endmodule
